// File: rtl/calculator_seq_param.sv
// Parametrised multi-cycle calculator: add/sub in one step,
// shift-add multiply and restoring divide over WIDTH steps.
module calculator_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             error,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       rop;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_dif;
  logic             div_ge;
  logic             iter_op;

  // One-step datapath: add/sub, one multiply step, one divide step.
  always_comb begin
    add_sum = {1'b0, ra} + {1'b0, rb};
    sub_dif = {1'b0, ra} - {1'b0, rb};
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, ra} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, rb};
    div_dif = div_sh[WIDTH-1:0] - rb;
    iter_op = (op == OP_MUL) ||
              (((op == OP_DIV) || (op == OP_REM)) && (b != '0));
  end

  // Control FSM with operand latch and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rop       <= '0;
      ra        <= '0;
      rb        <= '0;
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ra        <= a;
            rb        <= b;
            rop       <= op;
            busy      <= 1'b1;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            overflow  <= 1'b0;
            error     <= 1'b0;
            hi        <= '0;
            lo        <= (op == OP_MUL) ? b : a;
            state     <= iter_op ? S_ITER : S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            (rop == OP_ADD): begin
              result   <= add_sum[WIDTH-1:0];
              overflow <= add_sum[WIDTH];
            end
            (rop == OP_SUB): begin
              result   <= sub_dif[WIDTH-1:0];
              overflow <= sub_dif[WIDTH];
            end
            default: error <= 1'b1;
          endcase
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_ITER: begin
          if (cnt == LAST) begin
            unique case (1'b1)
              (rop == OP_MUL): begin
                result    <= lo;
                result_hi <= hi;
                overflow  <= |hi;
              end
              (rop == OP_DIV): begin
                result    <= lo;
                result_hi <= hi;
              end
              default: begin
                result    <= hi;
                result_hi <= lo;
              end
            endcase
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            if (rop == OP_MUL) begin
              hi <= mul_sum[WIDTH:1];
              lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
              hi <= div_ge ? div_dif : div_sh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], div_ge};
            end
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
